// File: rtl/usb_cmd_decoder_pkg.sv
// Shared opcodes and FSM state encoding for the USB control-word interpreter.
package usb_cmd_pkg;

    localparam logic [11:0] OP_CHN     = 12'hF0F;
    localparam logic [15:0] OP_ACQ_ON  = 16'hC0F0;
    localparam logic [15:0] OP_ACQ_OFF = 16'hC0F1;
    localparam logic [15:0] OP_CLR     = 16'hA0F0;
    localparam logic [7:0]  OP_LED     = 8'hB0;
    localparam logic [7:0]  OP_REG     = 8'hD0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_REG_WR    = 2'd3
    } state_e;

endpackage

// File: rtl/usb_cmd_decoder_fifo.sv
// Single-clock FIFO with registered read data; pointers carry an extra MSB
// so full and empty are distinguishable when the indices match.
module cmd_fifo_sync #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/usb_cmd_decoder.sv
// USB control-word interpreter: buffers 16-bit words, decodes them and drives
// channel select, acquisition run, data-FIFO clear pulse, LEDs and register writes.
module usb_cmd_decoder
    import usb_cmd_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH    = 16,
    parameter  int unsigned NUM_CHN       = 4,
    parameter  int unsigned LED_W         = 5,
    parameter  int unsigned CLR_PULSE_LEN = 4,
    parameter  int unsigned TIMEOUT_CYC   = 1024,
    localparam int unsigned CHN_W         = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [15:0]      cmd_data,
    output logic             cmd_ready,
    output logic [CHN_W-1:0] chn_select,
    output logic             acq_run,
    output logic             data_fifo_clr,
    output logic [LED_W-1:0] led,
    output logic             reg_wr,
    output logic [7:0]       reg_addr,
    output logic [15:0]      reg_data,
    output logic [7:0]       err_cnt,
    output logic             ovf_flag
);

    localparam int unsigned        TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]         CLR_LEN  = 8'(CLR_PULSE_LEN);

    logic        fifo_rd, fifo_full, fifo_empty;
    logic [15:0] fifo_dout;

    state_e           state_q, state_d;
    logic [CHN_W-1:0] chn_q, chn_d;
    logic             acq_run_q, acq_run_d;
    logic [7:0]       clr_cnt_q, clr_cnt_d;
    logic             data_fifo_clr_q, data_fifo_clr_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             reg_wr_q, reg_wr_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [15:0]      reg_data_q, reg_data_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             ovf_q, ovf_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_inc;

    cmd_fifo_sync #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (cmd_valid),
        .din   (cmd_data),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign fifo_rd   = ((state_q == ST_IDLE) || (state_q == ST_WAIT_DATA)) && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        chn_d      = chn_q;
        acq_run_d  = acq_run_q;
        led_d      = led_q;
        reg_wr_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        tmo_d      = tmo_q;
        err_inc    = 1'b0;
        ovf_d      = ovf_q | (cmd_valid && fifo_full);
        clr_cnt_d  = (clr_cnt_q != 8'd0) ? clr_cnt_q - 8'd1 : clr_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (fifo_dout[15:4] == OP_CHN) begin
                    if (32'(fifo_dout[3:0]) < NUM_CHN) begin
                        chn_d = fifo_dout[CHN_W-1:0];
                    end else begin
                        err_inc = 1'b1;
                    end
                end else if (fifo_dout == OP_ACQ_ON) begin
                    acq_run_d = 1'b1;
                end else if (fifo_dout == OP_ACQ_OFF) begin
                    acq_run_d = 1'b0;
                end else if (fifo_dout == OP_CLR) begin
                    // Reload rather than add: a repeat clear extends the pulse
                    clr_cnt_d = CLR_LEN;
                end else if (fifo_dout[15:8] == OP_LED) begin
                    led_d = ~fifo_dout[LED_W-1:0];
                end else if (fifo_dout[15:8] == OP_REG) begin
                    reg_addr_d = fifo_dout[7:0];
                    tmo_d      = '0;
                    state_d    = ST_WAIT_DATA;
                end else begin
                    err_inc = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (!fifo_empty) begin
                    state_d = ST_REG_WR;
                end else if (tmo_q == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_REG_WR: begin
                reg_data_d = fifo_dout;
                reg_wr_d   = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        data_fifo_clr_d = (clr_cnt_d != 8'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            chn_q           <= '0;
            acq_run_q       <= 1'b0;
            clr_cnt_q       <= '0;
            data_fifo_clr_q <= 1'b0;
            led_q           <= '1;
            reg_wr_q        <= 1'b0;
            reg_addr_q      <= '0;
            reg_data_q      <= '0;
            err_cnt_q       <= '0;
            ovf_q           <= 1'b0;
            tmo_q           <= '0;
        end else begin
            state_q         <= state_d;
            chn_q           <= chn_d;
            acq_run_q       <= acq_run_d;
            clr_cnt_q       <= clr_cnt_d;
            data_fifo_clr_q <= data_fifo_clr_d;
            led_q           <= led_d;
            reg_wr_q        <= reg_wr_d;
            reg_addr_q      <= reg_addr_d;
            reg_data_q      <= reg_data_d;
            err_cnt_q       <= err_cnt_d;
            ovf_q           <= ovf_d;
            tmo_q           <= tmo_d;
        end
    end

    assign chn_select    = chn_q;
    assign acq_run       = acq_run_q;
    assign data_fifo_clr = data_fifo_clr_q;
    assign led           = led_q;
    assign reg_wr        = reg_wr_q;
    assign reg_addr      = reg_addr_q;
    assign reg_data      = reg_data_q;
    assign err_cnt       = err_cnt_q;
    assign ovf_flag      = ovf_q;

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Bench for usb_cmd_decoder: timestamp-based command model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_usb_cmd_decoder;

    localparam int DEPTH   = 16;
    localparam int TMO     = 1024;
    localparam int CLR_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready;
    logic [1:0]  chn_select;
    logic        acq_run;
    logic        data_fifo_clr;
    logic [4:0]  led;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [15:0] reg_data;
    logic [7:0]  err_cnt;
    logic        ovf_flag;

    usb_cmd_decoder #(
        .FIFO_DEPTH    (16),
        .NUM_CHN       (4),
        .LED_W         (5),
        .CLR_PULSE_LEN (4),
        .TIMEOUT_CYC   (1024)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .chn_select    (chn_select),
        .acq_run       (acq_run),
        .data_fifo_clr (data_fifo_clr),
        .led           (led),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .err_cnt       (err_cnt),
        .ovf_flag      (ovf_flag)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: words queued with acceptance order; a command is fetched on the first
    // edge the decoder is free, its effect lands one edge later.
    logic [15:0] mq[$];
    int          n, free_e, wait_start, clr_end, wr_edge;
    bit          waiting, pend, pend_data, acc;
    logic [15:0] pend_w;
    logic [1:0]  e_chn;
    logic        e_acq, e_ovf;
    logic [4:0]  e_led;
    logic [7:0]  e_addr, e_err;
    logic [15:0] e_data;

    task automatic bump_err();
        e_err = (e_err == 8'hFF) ? 8'hFF : e_err + 8'd1;
    endtask

    task automatic apply(input logic [15:0] w);
        if (w[15:4] == 12'hF0F) begin
            if (w[3:0] < 4) e_chn = w[1:0];
            else bump_err();
        end else if (w == 16'hC0F0) e_acq = 1'b1;
        else if (w == 16'hC0F1) e_acq = 1'b0;
        else if (w == 16'hA0F0) clr_end = n + CLR_LEN;
        else if (w[15:8] == 8'hB0) e_led = ~w[4:0];
        else if (w[15:8] == 8'hD0) e_addr = w[7:0];
        else bump_err();
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            n = 0; free_e = 0; wait_start = 0; clr_end = 0; wr_edge = -1;
            waiting = 0; pend = 0; pend_data = 0; pend_w = '0;
            e_chn = '0; e_acq = 0; e_ovf = 0; e_led = 5'h1F;
            e_addr = '0; e_err = '0; e_data = '0;
        end else begin
            n++;
            acc = cmd_valid && (mq.size() < DEPTH);
            if (cmd_valid && !acc) e_ovf = 1'b1;
            if (pend) begin
                pend = 0;
                if (pend_data) begin
                    e_data = pend_w;
                    wr_edge = n;
                end else begin
                    apply(pend_w);
                end
            end
            if (!waiting) begin
                if (n >= free_e && mq.size() > 0) begin
                    pend_w = mq.pop_front();
                    pend = 1; pend_data = 0; free_e = n + 2;
                    if (pend_w[15:8] == 8'hD0) begin
                        waiting = 1; wait_start = n + 2;
                    end
                end
            end else if (n >= wait_start) begin
                if (mq.size() > 0) begin
                    pend_w = mq.pop_front();
                    pend = 1; pend_data = 1; waiting = 0; free_e = n + 2;
                end else if (n == wait_start + TMO - 1) begin
                    bump_err();
                    waiting = 0; free_e = n + 1;
                end
            end
            if (acc) mq.push_back(cmd_data);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cmd_ready", cmd_ready, mq.size() < DEPTH);
            check("chn_select", chn_select, e_chn);
            check("acq_run", acq_run, e_acq);
            check("data_fifo_clr", data_fifo_clr, n < clr_end);
            check("led", led, e_led);
            check("reg_wr", reg_wr, n == wr_edge);
            check("reg_addr", reg_addr, e_addr);
            check("reg_data", reg_data, e_data);
            check("err_cnt", err_cnt, e_err);
            check("ovf_flag", ovf_flag, e_ovf);
        end
    end

    task automatic push(input logic [15:0] w);
        cmd_valid = 1'b1;
        cmd_data  = w;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led"}, led, 5'h1F);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_chn"}, chn_select, 2'd0);
        check({tag, "_acq"}, acq_run, 1'b0);
        check({tag, "_clr"}, data_fifo_clr, 1'b0);
        check({tag, "_reg_wr"}, reg_wr, 1'b0);
        check({tag, "_reg_addr"}, reg_addr, 8'h00);
        check({tag, "_reg_data"}, reg_data, 16'h0000);
        check({tag, "_err"}, err_cnt, 8'h00);
        check({tag, "_ovf"}, ovf_flag, 1'b0);
    endtask

    int          cnt, acc_cnt;
    logic [7:0]  cap_addr;
    logic [15:0] cap_data;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        idle(2);

        // Channel select: effect visible two edges after acceptance
        push(16'hF0F2);
        check("chn_latency", chn_select, 2'd0);
        idle(2);
        check("chn_sel2", chn_select, 2'd2);
        check("chn_err0", err_cnt, 8'd0);
        push(16'hF0F7);
        idle(2);
        check("chn_bad_keep", chn_select, 2'd2);
        check("chn_bad_err", err_cnt, 8'd1);
        idle(2);

        // Single clear pulse
        push(16'hA0F0);
        cnt = 0;
        repeat (10) begin
            if (data_fifo_clr) cnt++;
            @(negedge clk);
        end
        check("clr_len", cnt, 4);

        // Reload two cycles into the pulse
        push(16'hA0F0);
        idle(1);
        push(16'hA0F0);
        cnt = 0;
        repeat (12) begin
            if (data_fifo_clr) cnt++;
            @(negedge clk);
        end
        check("clr_extend", cnt, 6);

        // Acquisition stop mid-pulse leaves the pulse intact
        push(16'hC0F0);
        idle(3);
        check("acq_on", acq_run, 1'b1);
        push(16'hA0F0);
        idle(1);
        push(16'hC0F1);
        cnt = 0;
        repeat (10) begin
            if (data_fifo_clr) cnt++;
            @(negedge clk);
        end
        check("clr_acq_off_len", cnt, 4);
        check("acq_off", acq_run, 1'b0);

        // Two-word register writes; second one carries a command-like payload
        push(16'hD012);
        push(16'h5A5A);
        cnt = 0;
        repeat (10) begin
            if (reg_wr) begin
                cnt++; cap_addr = reg_addr; cap_data = reg_data;
            end
            @(negedge clk);
        end
        check("regwr_count", cnt, 1);
        check("regwr_addr", cap_addr, 8'h12);
        check("regwr_data", cap_data, 16'h5A5A);
        push(16'hD034);
        push(16'hF0F1);
        idle(8);
        check("regwr2_data", reg_data, 16'hF0F1);
        check("regwr2_chn", chn_select, 2'd2);
        check("regwr2_addr", reg_addr, 8'h34);

        // Missing data word times out
        push(16'hD012);
        idle(1000);
        check("tmo_early", err_cnt, 8'd1);
        idle(40);
        check("tmo_err", err_cnt, 8'd2);
        push(16'hF0F1);
        idle(2);
        check("tmo_back_idle", chn_select, 2'd1);
        idle(2);

        // Overflow burst: writes every cycle, decoder drains one every two
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = 16'hB000 | 16'(i);
            if (cmd_ready) acc_cnt++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("ovf_flag_set", ovf_flag, 1'b1);
        idle(100);
        check("ovf_accepted", acc_cnt, 35);
        check("ovf_last_led", led, 5'b11001);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) begin
            push(16'h1234);
            idle(1);
        end
        idle(4);
        check("err_sat", err_cnt, 8'hFF);

        // Async reset mid WAIT_DATA and mid clear pulse, with words still buffered
        push(16'hA0F0);
        push(16'hD055);
        push(16'hB003);
        push(16'hB004);
        idle(1);
        check("pre_rst_clr", data_fifo_clr, 1'b1);
        #2 reset = 1'b1;
        #1 check_reset_values("arst");
        @(negedge clk);
        reset = 1'b0;
        idle(20);
        check("post_rst_led", led, 5'h1F);
        check("post_rst_reg_addr", reg_addr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1);
    end

endmodule
